// File: rtl/noc_credit_arbiter_if.sv
// -----------------------------------------------------------------------------
// noc_credit_arbiter_if
// Bundles the requester-side handshake, the downstream credit return and the
// arbiter status outputs of one NoC output link.
//   master : requester/downstream side (drives req_i, last_i, credit_return_i)
//   slave  : arbiter side (drives grants, link select and credit status)
// Signals:
//   req_i / last_i       per-requester flit valid and tail-flit marker
//   gnt_o                one-hot-or-zero grant
//   out_valid_o          a flit moves this cycle
//   out_sel_o            index of the granted requester (0 when idle)
//   credit_return_i      one downstream credit returned this cycle
//   credits_o            current credit count
//   credits_low_o        credit count at or below the low-water level
//   credits_full_o       credit count at its maximum
//   locked_o             link held by a packet in flight
//   overflow_err_o       sticky credit-overflow error
// -----------------------------------------------------------------------------
interface noc_credit_arbiter_if #(
  parameter int N_REQ           = 4,
  parameter int SEL_BITWIDTH    = 2,
  parameter int CREDIT_BITWIDTH = 4
);
  logic [N_REQ-1:0]           req_i;
  logic [N_REQ-1:0]           last_i;
  logic [N_REQ-1:0]           gnt_o;
  logic                       out_valid_o;
  logic [SEL_BITWIDTH-1:0]    out_sel_o;
  logic                       credit_return_i;
  logic [CREDIT_BITWIDTH-1:0] credits_o;
  logic                       credits_low_o;
  logic                       credits_full_o;
  logic                       locked_o;
  logic                       overflow_err_o;

  modport master (
    output req_i, last_i, credit_return_i,
    input  gnt_o, out_valid_o, out_sel_o, credits_o, credits_low_o,
           credits_full_o, locked_o, overflow_err_o
  );

  modport slave (
    input  req_i, last_i, credit_return_i,
    output gnt_o, out_valid_o, out_sel_o, credits_o, credits_low_o,
           credits_full_o, locked_o, overflow_err_o
  );
endinterface

// File: rtl/noc_credit_arbiter.sv
// -----------------------------------------------------------------------------
// noc_credit_arbiter
// Wormhole round-robin arbiter with credit-based flow control for a single NoC
// output link. Requesters compete round-robin for the link; once a multi-flit
// packet starts, the link stays locked to its owner until the tail flit has
// gone. A local up/down counter mirrors free space in the downstream buffer and
// no flit is granted while it is zero.
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  asynchronous active-low reset
//   bus     noc_credit_arbiter_if.slave (handshake, credits, status)
// Grant, out_valid and out_sel are combinational from req/last and registered
// state; all credit and lock status outputs come straight from flops.
// -----------------------------------------------------------------------------
module noc_credit_arbiter #(
  parameter int N_REQ            = 4,
  parameter int SEL_BITWIDTH     = 2,
  parameter int CREDIT_BITWIDTH  = 4,
  parameter int MAX_CREDITS      = 8,
  parameter int LOW_CREDIT_LEVEL = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  noc_credit_arbiter_if.slave   bus
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  localparam logic [SEL_BITWIDTH-1:0]    SEL_ZERO    = {SEL_BITWIDTH{1'b0}};
  localparam logic [SEL_BITWIDTH-1:0]    SEL_ONE     = SEL_BITWIDTH'(1);
  localparam logic [SEL_BITWIDTH-1:0]    LAST_IDX    = SEL_BITWIDTH'(N_REQ - 1);
  localparam logic [CREDIT_BITWIDTH-1:0] CRED_ZERO   = {CREDIT_BITWIDTH{1'b0}};
  localparam logic [CREDIT_BITWIDTH-1:0] CRED_ONE    = CREDIT_BITWIDTH'(1);
  localparam logic [CREDIT_BITWIDTH-1:0] CRED_MAX    = CREDIT_BITWIDTH'(MAX_CREDITS);
  localparam logic [CREDIT_BITWIDTH-1:0] CRED_LOW    = CREDIT_BITWIDTH'(LOW_CREDIT_LEVEL);
  localparam logic                       LOW_AT_MAX  = (CRED_MAX <= CRED_LOW);

  // Registered state
  state_e                     state_r;
  logic [SEL_BITWIDTH-1:0]    owner_r;
  logic [SEL_BITWIDTH-1:0]    ptr_r;
  logic [CREDIT_BITWIDTH-1:0] credits_r;
  logic                       overflow_r;
  logic                       credits_low_r;
  logic                       credits_full_r;
  logic                       locked_r;

  // Combinational arbitration and next-state values
  logic                       avail_s;
  logic                       found_s;
  logic [SEL_BITWIDTH-1:0]    winner_s;
  logic [SEL_BITWIDTH-1:0]    cand_s;
  logic [N_REQ-1:0]           gnt_s;
  logic [SEL_BITWIDTH-1:0]    sel_s;
  logic [SEL_BITWIDTH-1:0]    sel_inc_s;
  logic                       xfer_s;
  logic                       xfer_last_s;
  state_e                     state_nxt_s;
  logic [SEL_BITWIDTH-1:0]    owner_nxt_s;
  logic [SEL_BITWIDTH-1:0]    ptr_nxt_s;
  logic [CREDIT_BITWIDTH-1:0] credits_nxt_s;
  logic                       overflow_nxt_s;

  assign avail_s = (credits_r != CRED_ZERO);

  // Round-robin search: first requesting index at or above ptr, with wrap.
  always_comb begin
    found_s  = 1'b0;
    winner_s = SEL_ZERO;
    cand_s   = ptr_r;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found_s && bus.req_i[cand_s]) begin
        found_s  = 1'b1;
        winner_s = cand_s;
      end else begin
        found_s  = found_s;
      end
      cand_s = (cand_s == LAST_IDX) ? SEL_ZERO : (cand_s + SEL_ONE);
    end
  end

  // Grant generation: owner only while locked, round-robin winner when idle;
  // nothing at all without a credit.
  always_comb begin
    gnt_s  = {N_REQ{1'b0}};
    sel_s  = SEL_ZERO;
    xfer_s = 1'b0;
    if (avail_s) begin
      if (state_r == ST_LOCKED) begin
        // A stalled owner keeps the link; others are not back-filled.
        if (bus.req_i[owner_r]) begin
          gnt_s[owner_r] = 1'b1;
          sel_s          = owner_r;
          xfer_s         = 1'b1;
        end else begin
          xfer_s = 1'b0;
        end
      end else if (found_s) begin
        gnt_s[winner_s] = 1'b1;
        sel_s           = winner_s;
        xfer_s          = 1'b1;
      end else begin
        xfer_s = 1'b0;
      end
    end else begin
      xfer_s = 1'b0;
    end
    xfer_last_s = xfer_s & bus.last_i[sel_s];
    sel_inc_s   = (sel_s == LAST_IDX) ? SEL_ZERO : (sel_s + SEL_ONE);
  end

  // Next-state for the packet lock, round-robin pointer and credit counter.
  always_comb begin
    state_nxt_s    = state_r;
    owner_nxt_s    = owner_r;
    ptr_nxt_s      = ptr_r;
    credits_nxt_s  = credits_r;
    overflow_nxt_s = overflow_r;

    case (state_r)
      ST_IDLE: begin
        if (xfer_s && xfer_last_s) begin
          ptr_nxt_s = sel_inc_s;
        end else if (xfer_s) begin
          state_nxt_s = ST_LOCKED;
          owner_nxt_s = sel_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (xfer_last_s) begin
          state_nxt_s = ST_IDLE;
          ptr_nxt_s   = sel_inc_s;
        end else begin
          state_nxt_s = ST_LOCKED;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    // A transfer and a return in the same cycle cancel out.
    case ({xfer_s, bus.credit_return_i})
      2'b10: begin
        credits_nxt_s = credits_r - CRED_ONE;
      end
      2'b01: begin
        if (credits_r == CRED_MAX) begin
          overflow_nxt_s = 1'b1;
        end else begin
          credits_nxt_s = credits_r + CRED_ONE;
        end
      end
      default: begin
        credits_nxt_s = credits_r;
      end
    endcase
  end

  // State, counter and status flops; status flags are precomputed from the
  // next credit value so they come directly from registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r        <= ST_IDLE;
      owner_r        <= SEL_ZERO;
      ptr_r          <= SEL_ZERO;
      credits_r      <= CRED_MAX;
      overflow_r     <= 1'b0;
      credits_low_r  <= LOW_AT_MAX;
      credits_full_r <= 1'b1;
      locked_r       <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      owner_r        <= owner_nxt_s;
      ptr_r          <= ptr_nxt_s;
      credits_r      <= credits_nxt_s;
      overflow_r     <= overflow_nxt_s;
      credits_low_r  <= (credits_nxt_s <= CRED_LOW);
      credits_full_r <= (credits_nxt_s == CRED_MAX);
      locked_r       <= (state_nxt_s == ST_LOCKED);
    end
  end

  assign bus.gnt_o          = gnt_s;
  assign bus.out_valid_o    = xfer_s;
  assign bus.out_sel_o      = sel_s;
  assign bus.credits_o      = credits_r;
  assign bus.credits_low_o  = credits_low_r;
  assign bus.credits_full_o = credits_full_r;
  assign bus.locked_o       = locked_r;
  assign bus.overflow_err_o = overflow_r;

endmodule

// File: tb/tb_noc_credit_arbiter.sv
// -----------------------------------------------------------------------------
// tb_noc_credit_arbiter
// Self-checking bench: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of the link (credit count, pointer,
// lock owner) kept as plain integers.
// -----------------------------------------------------------------------------
module tb_noc_credit_arbiter;
  localparam int N    = 4;
  localparam int SELW = 2;
  localparam int CW   = 4;
  localparam int MAXC = 8;
  localparam int LOWL = 2;

  logic clk = 1'b0;
  logic rst_n;

  noc_credit_arbiter_if #(.N_REQ(N), .SEL_BITWIDTH(SELW), .CREDIT_BITWIDTH(CW)) bus ();

  noc_credit_arbiter #(
    .N_REQ(N), .SEL_BITWIDTH(SELW), .CREDIT_BITWIDTH(CW),
    .MAX_CREDITS(MAXC), .LOW_CREDIT_LEVEL(LOWL)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_cred;
  int m_ptr;
  int m_owner;
  bit m_locked;
  bit m_err;

  logic [N-1:0] g;
  int           gcount;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cred   = MAXC;
    m_ptr    = 0;
    m_owner  = 0;
    m_locked = 1'b0;
    m_err    = 1'b0;
  endtask

  // One cycle: drive inputs, check all outputs against the model, advance model.
  task automatic step(input logic [N-1:0] req, input logic [N-1:0] last,
                      input logic ret, output logic [N-1:0] got);
    int           win;
    logic [N-1:0] eg;
    @(negedge clk);
    bus.req_i           = req;
    bus.last_i          = last;
    bus.credit_return_i = ret;
    #1;
    win = -1;
    eg  = '0;
    if (m_cred > 0) begin
      if (m_locked) begin
        if (req[m_owner]) win = m_owner;
      end else begin
        for (int k = 0; k < N; k++)
          if (win < 0 && req[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      end
    end
    if (win >= 0) eg[win] = 1'b1;
    check("gnt",      bus.gnt_o,          eg);
    check("valid",    bus.out_valid_o,    (win >= 0));
    check("sel",      bus.out_sel_o,      (win >= 0) ? win : 0);
    check("credits",  bus.credits_o,      m_cred);
    check("low",      bus.credits_low_o,  (m_cred <= LOWL));
    check("full",     bus.credits_full_o, (m_cred == MAXC));
    check("locked",   bus.locked_o,       m_locked);
    check("overflow", bus.overflow_err_o, m_err);
    got = bus.gnt_o;
    if (win >= 0) begin
      if (last[win]) begin
        m_locked = 1'b0;
        m_ptr    = (win + 1) % N;
      end else begin
        m_locked = 1'b1;
        m_owner  = win;
      end
    end
    m_cred = m_cred - ((win >= 0) ? 1 : 0) + (ret ? 1 : 0);
    if (m_cred > MAXC) begin
      m_cred = MAXC;
      m_err  = 1'b1;
    end
  endtask

  // Asynchronous reset pulse; checks reset values while reset is held.
  task automatic do_reset();
    @(negedge clk);
    rst_n               = 1'b0;
    bus.req_i           = '0;
    bus.last_i          = '0;
    bus.credit_return_i = 1'b0;
    #1;
    check("rst_locked",   bus.locked_o,       1'b0);
    check("rst_credits",  bus.credits_o,      MAXC);
    check("rst_gnt",      bus.gnt_o,          4'b0000);
    check("rst_sel",      bus.out_sel_o,      2'd0);
    check("rst_full",     bus.credits_full_o, 1'b1);
    check("rst_low",      bus.credits_low_o,  1'b0);
    check("rst_overflow", bus.overflow_err_o, 1'b0);
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n               = 1'b0;
    bus.req_i           = '0;
    bus.last_i          = '0;
    bus.credit_return_i = 1'b0;
    model_reset();

    // Fairness with single-flit packets; returns start after 4 grants.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, 4'b1111, (i >= 4), g);
      check("rr_order", g, 4'b0001 << (i % 4));
    end

    // Three-flit packet from requester 2 while requester 0 waits.
    do_reset();
    step(4'b0001, 4'b0001, 1'b0, g);
    step(4'b0010, 4'b0010, 1'b0, g);
    step(4'b0101, 4'b0000, 1'b0, g);
    check("pkt_flit1", g, 4'b0100);
    step(4'b0101, 4'b0000, 1'b0, g);
    check("pkt_flit2", g, 4'b0100);
    step(4'b0001, 4'b0000, 1'b0, g);
    check("pkt_stall", g, 4'b0000);
    step(4'b0101, 4'b0100, 1'b0, g);
    check("pkt_flit3", g, 4'b0100);
    step(4'b1001, 4'b1001, 1'b0, g);
    check("after_pkt_ptr3", g, 4'b1000);
    step(4'b0001, 4'b0001, 1'b0, g);
    check("after_pkt_req0", g, 4'b0001);

    // Credit drain, no returns, then a single return.
    do_reset();
    gcount = 0;
    for (int i = 0; i < 10; i++) begin
      step(4'b0010, 4'b0010, 1'b0, g);
      if (g != 4'b0000) gcount++;
    end
    check("drain_count", gcount, 8);
    check("drain_empty", g, 4'b0000);
    step(4'b0010, 4'b0010, 1'b1, g);
    check("no_bypass", g, 4'b0000);
    step(4'b0010, 4'b0010, 1'b0, g);
    check("return_grant", g, 4'b0010);
    step(4'b0000, 4'b0000, 1'b0, g);

    // Transfer and return in the same cycle at credits = 5.
    do_reset();
    for (int i = 0; i < 3; i++) step(4'b1000, 4'b1000, 1'b0, g);
    step(4'b1000, 4'b1000, 1'b1, g);
    @(posedge clk);
    #1;
    check("same_cycle_credits", bus.credits_o, 5);

    // Overflow is sticky until reset.
    do_reset();
    step(4'b0000, 4'b0000, 1'b1, g);
    @(posedge clk);
    #1;
    check("overflow_set", bus.overflow_err_o, 1'b1);
    check("overflow_hold_credits", bus.credits_o, MAXC);
    for (int i = 0; i < 4; i++) step(4'b0100, 4'b0100, 1'b0, g);
    check("overflow_sticky", bus.overflow_err_o, 1'b1);

    // Reset mid-packet drops the lock; order restarts from index 0.
    do_reset();
    step(4'b0100, 4'b0000, 1'b0, g);
    step(4'b0100, 4'b0000, 1'b0, g);
    check("mid_locked", bus.locked_o, 1'b1);
    do_reset();
    step(4'b1111, 4'b1111, 1'b0, g);
    check("post_reset_rr", g, 4'b0001);

    // Random traffic with periodic resets.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      logic [N-1:0] rq;
      logic [N-1:0] ls;
      logic         rt;
      if (i % 200 == 199) do_reset();
      rq = N'($urandom);
      ls = N'($urandom) & N'($urandom);
      rt = ($urandom_range(0, 99) < 45);
      step(rq, ls, rt, g);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/noc_credit_arbiter.md
# noc_credit_arbiter

Wormhole round-robin arbiter with credit-based flow control for one NoC output link. It shares the link between `N_REQ` input requesters. It tracks downstream buffer space with an internal up/down credit counter, and locks the link to one requester until that requester's packet tail flit has gone. It sits between the router input ports and an output port, in front of the downstream FIFO that returns credits.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters; ≥2.
- `SEL_BITWIDTH`, 2: width of `out_sel_o`; must equal ceil(log2(`N_REQ`)).
- `CREDIT_BITWIDTH`, 4: credit counter width; must hold `MAX_CREDITS`.
- `MAX_CREDITS`, 8: downstream buffer depth; counter reset value.
- `LOW_CREDIT_LEVEL`, 2: `credits_low_o` asserts when credits ≤ this value.

Ports:
- `clk_i`, in, 1: clock, rising edge.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `req_i`, in, `N_REQ`: per-requester flit valid.
- `last_i`, in, `N_REQ`: per-requester tail-flit marker; only meaningful together with `req_i`.
- `gnt_o`, out, `N_REQ`: one-hot-or-zero grant; a flit transfers when its bit is 1.
- `out_valid_o`, out, 1: OR of `gnt_o`.
- `out_sel_o`, out, `SEL_BITWIDTH`: index of the granted requester; 0 when idle.
- `credit_return_i`, in, 1: one credit returned by downstream this cycle.
- `credits_o`, out, `CREDIT_BITWIDTH`: current credit count.
- `credits_low_o`, out, 1: credits ≤ `LOW_CREDIT_LEVEL`.
- `credits_full_o`, out, 1: credits == `MAX_CREDITS`.
- `locked_o`, out, 1: FSM is in LOCKED.
- `overflow_err_o`, out, 1: sticky; set on credit return at `MAX_CREDITS`.

## Operation
- State registers:
  - FSM: IDLE or LOCKED.
  - `owner` index.
  - Round-robin pointer `ptr`.
  - Credit counter.
  - Error flag.
- `avail` = credits ≠ 0. No grant is ever issued while `avail` is 0.
- IDLE:
  - The winner is the first `req_i` bit found searching from `ptr` upward with wrap.
  - If `avail` and a winner exists, the winner's `gnt_o` bit is set.
  - Transfer with its `last_i` = 1 (single-flit packet): stay IDLE; `ptr` ← winner+1 mod `N_REQ`.
  - Transfer with `last_i` = 0: go to LOCKED; `owner` ← winner.
- LOCKED:
  - `gnt_o[owner]` = `req_i[owner]` & `avail`. All other grants are 0, even if the owner is stalled.
  - Transfer with `last_i[owner]` = 1: go to IDLE; `ptr` ← `owner`+1 mod `N_REQ`.
- Credit counter, applied at the next clock edge:
  - Transfer and no return: decrement.
  - Return and no transfer: increment.
  - Both in the same cycle: unchanged.
  - Return while at `MAX_CREDITS` with no transfer: counter holds; `overflow_err_o` ← 1.
  - Underflow cannot occur, because grants require `avail`.
- `overflow_err_o` clears only on reset.
- Reset values:
  - State IDLE; `ptr` = 0; `owner` = 0.
  - credits = `MAX_CREDITS`.
  - `gnt_o` = 0, `out_valid_o` = 0, `out_sel_o` = 0.
  - `credits_full_o` = 1; `credits_low_o` = 0 (for `LOW_CREDIT_LEVEL` < `MAX_CREDITS`).
  - `locked_o` = 0; `overflow_err_o` = 0.
- Reset asserted mid-packet drops the lock immediately. No flit replay.

## Timing
- `gnt_o`, `out_valid_o` and `out_sel_o` are combinational from `req_i`, `last_i` and registered state. There is zero-cycle latency from request to grant.
- `credits_o`, `credits_low_o`, `credits_full_o` and `locked_o` are driven from registers only. They change one edge after the causing event.
- A credit returned in cycle t can enable a grant in cycle t+1 at the earliest. Same-cycle bypass is not allowed.
- The packet lock persists across any number of stall cycles, whether from the owner's `req_i` dropping or from zero credits.
- Fairness: with all requesters continuously sending single-flit packets and credits available, each requester is granted once in every `N_REQ` cycles.

## Test plan
- Reset, then all `req_i` = 4'b1111 and `last_i` = 4'b1111, with `credit_return_i` = 1 every cycle after the first 4 grants → grants 0,1,2,3,0; credits 8→4 then steady at 4; no error.
- Requester 2 sends a 3-flit packet (`last_i` only on flit 3) while requester 0 also requests → `gnt_o` = 4'b0100 for 3 transfers; `locked_o` = 1 during the packet; requester 0 is granted on the next cycle; `ptr` = 3.
- No credit returns, requester 1 streaming → exactly 8 grants; credits reach 0; `gnt_o` = 0 afterwards; `credits_low_o` rises when credits reach 2; one return → one more grant the following cycle.
- Transfer and `credit_return_i` in the same cycle at credits = 5 → credits stay 5.
- `credit_return_i` = 1 at credits = 8 with no transfer → credits stay 8; `overflow_err_o` = 1 and remains 1 until `rst_ni` is low.
- `rst_ni` pulsed low while LOCKED mid-packet → `locked_o` = 0, credits = 8, `ptr` = 0 immediately; the next grant follows round-robin order from index 0.
